ring_step_monitor: RTL and testbench



---
 rtl/ring_mon_pkg.sv | 42 ++++
 rtl/ring_mon_sync.sv | 27 ++
 rtl/ring_step_monitor.sv | 173 +++++++++++++++++
 tb/tb_ring_step_monitor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the ring step monitor.
// Optional feature macro used by the monitor: RING_MON_DIR_EN (reverse steps).
package ring_mon_pkg;

  localparam int RING_W_DEF = 6;
  localparam int CNT_W_DEF  = 8;

  // Widest ring the classifier accepts; narrower rings are zero-extended.
  localparam int MAX_RING_W = 32;

  typedef logic [$clog2(MAX_RING_W)-1:0] ring_pos_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } mon_state_t;

  typedef struct packed {
    logic      legal;
    logic      idle;
    ring_pos_t idx;
  } onehot_t;

  // Classify a ring code: idle when no bit is set, legal when exactly one
  // bit is set; idx is the position of the highest set bit.
  function automatic onehot_t onehot_idx(input logic [MAX_RING_W-1:0] code);
    onehot_t r;
    int      ones;
    r    = '0;
    ones = 0;
    for (int i = 0; i < MAX_RING_W; i++) begin
      if (code[i]) begin
        ones  = ones + 1;
        r.idx = ring_pos_t'(i);
      end
    end
    r.idle  = (ones == 0);
    r.legal = (ones == 1);
    return r;
  endfunction

endpackage

// File: rtl/ring_mon_sync.sv
// Multi-stage synchronizer bringing the asynchronous ring flops into clk.
module ring_mon_sync
  import ring_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RING_W      = RING_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RING_W-1:0] i_ring,
  output logic [RING_W-1:0] o_sample
);

  logic [SYNC_STAGES-1:0][RING_W-1:0] r_sync;

  // Shift the raw ring code through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ring};
    end
  end

  assign o_sample = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ring_step_monitor.sv
// Ring step monitor: synchronizes the one-hot LED-chaser ring, tracks its
// position, counts revolutions and raises a sticky error on illegal codes
// or skipped steps.
// Optional feature: define RING_MON_DIR_EN to accept reverse single steps.
module ring_step_monitor
  import ring_mon_pkg::*;
#(
  parameter int RING_W      = RING_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RING_W-1:0]         ring_in,
  input  logic                      clr,
  output logic [$clog2(RING_W)-1:0] pos,
  output logic                      valid,
  output logic [CNT_W-1:0]          rev_count,
  output logic                      err,
  output logic                      dir
);

  localparam int               POS_W    = $clog2(RING_W);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(RING_W - 1);

  logic [RING_W-1:0]     w_s;
  logic [MAX_RING_W-1:0] w_s_ext;
  onehot_t               w_cls;
  logic [POS_W-1:0]      w_idx;
  logic [POS_W-1:0]      w_pos_fwd;
  logic [POS_W-1:0]      w_pos_nxt;
  logic                  w_err_evt;
  logic                  w_inc;
  logic                  w_dec;
  mon_state_t            w_state_nxt;

  mon_state_t            r_state;
  logic [POS_W-1:0]      r_pos;
  logic                  r_valid;
  logic [CNT_W-1:0]      r_rev;
  logic                  r_err;

`ifdef RING_MON_DIR_EN
  logic [POS_W-1:0]      w_pos_rev;
  logic                  w_dir_nxt;
  logic                  r_dir;
`endif

  ring_mon_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RING_W      (RING_W)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ring   (ring_in),
    .o_sample (w_s)
  );

  // Classify the synchronized sample (raw ring_in is never looked at).
  always_comb begin
    w_s_ext             = '0;
    w_s_ext[RING_W-1:0] = w_s;
    w_cls               = onehot_idx(w_s_ext);
    w_idx               = POS_W'(w_cls.idx);
  end

  assign w_pos_fwd = (r_pos == LAST_POS) ? '0 : r_pos + POS_W'(1);
`ifdef RING_MON_DIR_EN
  assign w_pos_rev = (r_pos == '0) ? LAST_POS : r_pos - POS_W'(1);
`endif

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= UNLOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next lock state, next position and step events from the classified sample.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_err_evt   = 1'b0;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
`ifdef RING_MON_DIR_EN
    w_dir_nxt   = r_dir;
`endif
    if (!w_cls.legal && !w_cls.idle) begin
      // Two or more bits set: flag it and drop the lock, position holds.
      w_err_evt   = 1'b1;
      w_state_nxt = UNLOCKED;
    end else if (w_cls.idle) begin
      // Empty ring (e.g. being reloaded): drop the lock quietly.
      w_state_nxt = UNLOCKED;
    end else begin
      case (r_state)
        UNLOCKED: begin
          w_pos_nxt   = w_idx;
          w_state_nxt = LOCKED;
        end
        LOCKED: begin
          if (w_idx != r_pos) begin
            w_pos_nxt = w_idx;
            if (w_idx == w_pos_fwd) begin
              w_inc = (r_pos == LAST_POS);
`ifdef RING_MON_DIR_EN
              w_dir_nxt = 1'b0;
            end else if (w_idx == w_pos_rev) begin
              w_dec     = (r_pos == '0);
              w_dir_nxt = 1'b1;
`endif
            end else begin
              w_err_evt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = UNLOCKED;
        end
      endcase
    end
  end

  // Output registers: position, validity, revolution count and sticky error.
  // clr loses to a same-cycle error but wins over a same-cycle wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos   <= '0;
      r_valid <= 1'b0;
      r_rev   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_pos   <= w_pos_nxt;
      r_valid <= w_cls.legal;
      if (clr) begin
        r_rev <= '0;
      end else if (w_inc) begin
        r_rev <= r_rev + CNT_W'(1);
      end else if (w_dec) begin
        r_rev <= r_rev - CNT_W'(1);
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end else if (clr) begin
        r_err <= 1'b0;
      end
    end
  end

`ifdef RING_MON_DIR_EN
  // Direction of the most recent accepted step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir <= 1'b0;
    end else begin
      r_dir <= w_dir_nxt;
    end
  end

  assign dir = r_dir;
`else
  assign dir = 1'b0;
`endif

  assign pos       = r_pos;
  assign valid     = r_valid;
  assign rev_count = r_rev;
  assign err       = r_err;

endmodule

// File: tb/tb_ring_step_monitor.sv
// Self-checking bench for ring_step_monitor: directed scenarios plus a
// randomized ring walk compared cycle by cycle against a behavioural model.
// Honours RING_MON_DIR_EN the same way the design does.
module tb_ring_step_monitor;

  localparam int RW = 6;
  localparam int CW = 8;
  localparam int SS = 2;
  localparam int PW = $clog2(RW);
`ifdef RING_MON_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [RW-1:0] ring_in = '0;
  logic          clr     = 1'b0;
  logic [PW-1:0] pos;
  logic          valid;
  logic [CW-1:0] rev_count;
  logic          err;
  logic          dir;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [RW-1:0] m_hist[$];
  bit            m_locked;
  int            m_pos;
  int            m_valid;
  int            m_rev;
  int            m_err;
  int            m_dir;

  ring_step_monitor #(
    .RING_W      (RW),
    .CNT_W       (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ring_in   (ring_in),
    .clr       (clr),
    .pos       (pos),
    .valid     (valid),
    .rev_count (rev_count),
    .err       (err),
    .dir       (dir)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    repeat (SS) m_hist.push_back('0);
    m_locked = 1'b0;
    m_pos    = 0;
    m_valid  = 0;
    m_rev    = 0;
    m_err    = 0;
    m_dir    = 0;
  endtask

  // One clock of the model: the sample seen now is the ring value applied
  // SS clocks ago; positions are compared by modular distance.
  task automatic model_clk(input logic [RW-1:0] r, input logic c);
    logic [RW-1:0] s;
    int ones, n, d, delta;
    bit evt;
    m_hist.push_back(r);
    s     = m_hist.pop_front();
    ones  = $countones(s);
    n     = 0;
    for (int i = 0; i < RW; i++) if (s[i]) n = i;
    evt   = 1'b0;
    delta = 0;
    m_valid = (ones == 1) ? 1 : 0;
    if (ones > 1) begin
      evt      = 1'b1;
      m_locked = 1'b0;
    end else if (ones == 0) begin
      m_locked = 1'b0;
    end else if (!m_locked) begin
      m_locked = 1'b1;
      m_pos    = n;
    end else begin
      d = (n - m_pos + RW) % RW;
      if (d == 1) begin
        if (n == 0) delta = 1;
        m_pos = n;
        if (DIR_EN) m_dir = 0;
      end else if (DIR_EN && d == RW - 1) begin
        if (n == RW - 1) delta = -1;
        m_pos = n;
        m_dir = 1;
      end else if (d != 0) begin
        evt   = 1'b1;
        m_pos = n;
      end
    end
    if (c) m_rev = 0;
    else   m_rev = (m_rev + delta + (1 << CW)) % (1 << CW);
    if (evt)    m_err = 1;
    else if (c) m_err = 0;
  endtask

  task automatic compare_model();
    check_eq("pos",   pos,       m_pos);
    check_eq("valid", valid,     m_valid);
    check_eq("rev",   rev_count, m_rev);
    check_eq("err",   err,       m_err);
    check_eq("dir",   dir,       m_dir);
  endtask

  // Called at a falling edge: apply inputs, clock once, check at next falling edge.
  task automatic step(input logic [RW-1:0] r, input logic c);
    ring_in = r;
    clr     = c;
    @(posedge clk);
    model_clk(r, c);
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input logic [RW-1:0] r, input int cycles);
    repeat (cycles) step(r, 1'b0);
  endtask

  function automatic logic [RW-1:0] onehot(input int p);
    logic [RW-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pos"},   pos,       0);
    check_eq({tag, "_valid"}, valid,     0);
    check_eq({tag, "_rev"},   rev_count, 0);
    check_eq({tag, "_err"},   err,       0);
    check_eq({tag, "_dir"},   dir,       0);
  endtask

  initial begin
    logic [RW-1:0] code;
    int cur, a, hold, b1, b2;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    model_reset();
    rst_n = 1'b1;

    // One pass round the ring starting at bit5
    drive(onehot(5), 4);
    for (int p = 0; p < RW; p++) drive(onehot(p), 4);
    check_eq("p1_pos",   pos,       5);
    check_eq("p1_valid", valid,     1);
    check_eq("p1_rev",   rev_count, 1);
    check_eq("p1_err",   err,       0);

    // 300 revolutions after a clear
    step(onehot(5), 1'b1);
    for (int r = 0; r < 300; r++)
      for (int p = 0; p < RW; p++) drive(onehot(p), 2);
    drive(onehot(5), 3);
    check_eq("p2_rev", rev_count, 44);
    check_eq("p2_err", err,       0);

    // Skip from pos 1 to pos 3, then clear
    drive(onehot(0), 4);
    drive(onehot(1), 4);
    drive(onehot(3), 4);
    check_eq("p3_err", err,       1);
    check_eq("p3_pos", pos,       3);
    check_eq("p3_rev", rev_count, 45);
    step(onehot(3), 1'b1);
    drive(onehot(3), 3);
    check_eq("p3_clr_err", err,       0);
    check_eq("p3_clr_rev", rev_count, 0);

    // Illegal code, then relock
    drive(6'b000011, 4);
    check_eq("p4_err",   err,   1);
    check_eq("p4_valid", valid, 0);
    check_eq("p4_pos",   pos,   3);
    drive(onehot(2), 4);
    check_eq("p4_relock_pos",   pos,   2);
    check_eq("p4_relock_valid", valid, 1);
    step(onehot(2), 1'b1);
    drive(onehot(2), 3);
    check_eq("p4_relock_err", err, 0);

    // Idle ring then reload at bit5
    drive('0, 4);
    check_eq("p5_idle_valid", valid, 0);
    check_eq("p5_idle_pos",   pos,   2);
    drive(onehot(5), 4);
    check_eq("p5_pos", pos, 5);
    check_eq("p5_err", err, 0);
    drive(onehot(0), 4);
    check_eq("p5_rev", rev_count, 1);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1 check_all_zero("arst");
    model_reset();
    ring_in = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reverse wrap 0 -> 5
    drive(onehot(0), 4);
    drive(onehot(5), 4);
    check_eq("p6_pos", pos,       5);
    check_eq("p6_rev", rev_count, DIR_EN ? 255 : 0);
    check_eq("p6_dir", dir,       DIR_EN ? 1 : 0);
    check_eq("p6_err", err,       DIR_EN ? 0 : 1);

    // Randomized ring walk
    cur  = 5;
    code = onehot(cur);
    for (int k = 0; k < 800; k++) begin
      a = $urandom_range(0, 99);
      if (a < 55) begin
        cur  = (cur + 1) % RW;
        code = onehot(cur);
      end else if (a < 70) begin
        cur  = (cur + RW - 1) % RW;
        code = onehot(cur);
      end else if (a < 78) begin
        cur  = $urandom_range(0, RW - 1);
        code = onehot(cur);
      end else if (a < 84) begin
        code = '0;
      end else if (a < 90) begin
        b1   = $urandom_range(0, RW - 1);
        b2   = (b1 + 1 + $urandom_range(0, RW - 2)) % RW;
        code = onehot(b1) | onehot(b2);
      end
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) step(code, ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
